hdmi_i2c_config_seq: RTL and testbench

//  Sequencer and bit-level I2C write master for HDMI transmitter register setup.
//  - Drives `count` into the I2C table-data ROM.
//  - Consumes its 24-bit {dev_addr, reg, data} word.
//  - Issues one 3-byte I2C write per entry: START, 3 bytes each ACK-checked, STOP.
//  - Sits between the table ROM and the board I2C pins; runs once after boot.

---
 rtl/hdmi_i2c_config_seq.sv | 124 ++++++++++++
 tb/tb_hdmi_i2c_config_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c_config_seq.sv
// hdmi_i2c_config_seq: boot-time I2C table writer for an HDMI transmitter; `define HPD_RECONFIG_EN adds hot-plug rerun
module hdmi_i2c_config_seq #(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 100_000,
  parameter int LUT_SIZE = 12,
  parameter int MAX_RETRY = 3,
  parameter int BOOT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
`ifdef HPD_RECONFIG_EN
  input  logic hdmi_hpd,
`endif
  output logic [5:0] count,
  input  logic [23:0] table_data,
  output logic i2c_sclk,
  inout  wire i2c_sda,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
  localparam int DW = $clog2(QDIV + 1);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [3:0] {BOOT, LOAD, START, BIT, ACK, STOP, NEXT, DONE, ERR} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [BW-1:0] boot_cnt;
  logic [RW-1:0] retry;
  logic [1:0] phase, byte_cnt;
  logic [2:0] bit_cnt;
  logic [23:0] shreg;
  logic sda_oe, nack, qt, go, last, q3;
  assign busy = state != DONE && state != ERR;
  assign done = state == DONE;
  assign error = state == ERR;
  assign qt = div == DW'(QDIV - 1);
  assign q3 = qt && phase == 2'd3;
  assign last = count == 6'(LUT_SIZE - 1);
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
`ifdef HPD_RECONFIG_EN
  logic [2:0] hpd_s;
  always_ff @(posedge clock or posedge reset)
    if (reset) hpd_s <= '0;
    else hpd_s <= {hpd_s[1:0], hdmi_hpd};
  assign go = start | (hpd_s[1] & ~hpd_s[2]);
`else
  assign go = start;
`endif
  always_comb begin
    state_n = state;
    case (state)
      BOOT: state_n = boot_cnt == BW'(BOOT_CYCLES - 1) ? LOAD : BOOT;
      LOAD: state_n = (qt && phase == 2'd1) ? START : LOAD;
      START: state_n = q3 ? BIT : START;
      BIT: state_n = (q3 && bit_cnt == 3'd7) ? ACK : BIT;
      ACK: state_n = !q3 ? ACK : (nack || byte_cnt == 2'd2) ? STOP : BIT;
      STOP: state_n = !q3 ? STOP : !nack ? NEXT : (retry == RW'(MAX_RETRY)) ? ERR : LOAD;
      NEXT: state_n = last ? DONE : LOAD;
      default: state_n = go ? LOAD : state;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= BOOT;
      div <= '0;
      boot_cnt <= '0;
      retry <= '0;
      phase <= '0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      nack <= 1'b0;
      count <= '0;
      i2c_sclk <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      state <= state_n;
      div <= (!busy || qt) ? '0 : div + 1'b1;
      boot_cnt <= state == BOOT ? boot_cnt + 1'b1 : '0;
      phase <= state_n != state ? 2'd0 : qt ? phase + 2'd1 : phase;
      case (state)
        LOAD: if (qt && phase == 2'd1) begin
          shreg <= table_data;
          byte_cnt <= '0;
          nack <= 1'b0;
        end
        START: if (qt) begin
          i2c_sclk <= phase != 2'd3;
          sda_oe <= phase != 2'd0;
        end
        BIT: if (qt) begin
          i2c_sclk <= ^phase;
          if (phase == 2'd0) sda_oe <= ~shreg[23];
          if (phase == 2'd3) begin
            shreg <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ACK: if (qt) begin
          i2c_sclk <= ^phase;
          if (phase == 2'd0) sda_oe <= 1'b0;
          if (phase == 2'd2) nack <= i2c_sda;
          if (phase == 2'd3) byte_cnt <= byte_cnt + 2'd1;
        end
        STOP: if (qt) begin
          i2c_sclk <= phase != 2'd0;
          sda_oe <= ~phase[1];
          if (phase == 2'd3 && nack) retry <= retry + 1'b1;
        end
        NEXT: begin
          retry <= '0;
          if (!last) count <= count + 6'd1;
        end
        DONE, ERR: if (go) begin
          count <= '0;
          retry <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_hdmi_i2c_config_seq.sv
// tb_hdmi_i2c_config_seq: I2C slave + negedge ROM models, scenario table and attempt-level reference model
module tb_hdmi_i2c_config_seq;
  localparam int LUT = 12, MR = 3, BOOT = 100, BUDGET = 40000;
  typedef struct packed {logic [7:0] ent; logic [1:0] nb; logic [23:0] b;} rec_t;
  typedef struct {int ent; int byt; int times; bit exp_done; bit exp_err; int exp_cnt;} row_t;
  logic clock = 0, reset = 1, start = 0;
  logic [5:0] count;
  logic [23:0] table_data = '0;
  logic i2c_sclk, busy, done, error;
  logic sda_pull = 0;
  wire sda;
  assign sda = sda_pull ? 1'b0 : 1'bz;
  pullup pu (sda);
`ifdef HPD_RECONFIG_EN
  logic hpd = 0;
`endif
  hdmi_i2c_config_seq #(.CLK_HZ(4_000_000), .I2C_HZ(100_000), .LUT_SIZE(LUT), .MAX_RETRY(MR), .BOOT_CYCLES(BOOT)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
`ifdef HPD_RECONFIG_EN
    .hdmi_hpd(hpd),
`endif
    .count(count),
    .table_data(table_data),
    .i2c_sclk(i2c_sclk),
    .i2c_sda(sda),
    .busy(busy),
    .done(done),
    .error(error)
  );
  always #5 clock = ~clock;
  logic [23:0] rom [64];
  int nack_tab [64][MR+1];
  always @(negedge clock) table_data <= rom[count];
  rec_t obs [$];
  int bitn = 0, nbytes = 0, nk = 3, cur_ent = 0, last_ent = -1, run_att = 0;
  bit in_tx = 0, ack_ph = 0, p_scl = 1, p_sda = 1;
  logic [7:0] sh = '0;
  logic [23:0] got = '0;
  always @(i2c_sclk or sda or reset or busy) begin
    if (reset) begin
      in_tx = 0;
      ack_ph = 0;
      sda_pull = 0;
      last_ent = -1;
    end else if (!busy) last_ent = -1;
    else if (i2c_sclk && p_scl && !sda && p_sda) begin
      cur_ent = int'(count);
      run_att = cur_ent == last_ent ? run_att + 1 : 0;
      last_ent = cur_ent;
      nk = run_att <= MR ? nack_tab[cur_ent][run_att] : 3;
      in_tx = 1;
      ack_ph = 0;
      bitn = 0;
      nbytes = 0;
      got = '0;
    end else if (i2c_sclk && p_scl && sda && !p_sda && in_tx) begin
      obs.push_back({8'(cur_ent), 2'(nbytes), got});
      in_tx = 0;
    end else if (in_tx && i2c_sclk && !p_scl && !ack_ph && bitn < 8) begin
      sh = {sh[6:0], sda};
      bitn++;
    end else if (in_tx && !i2c_sclk && p_scl) begin
      if (ack_ph) begin
        sda_pull = 0;
        ack_ph = 0;
        bitn = 0;
        nbytes++;
      end else if (bitn == 8) begin
        got[23-8*nbytes -: 8] = sh;
        sda_pull = nbytes != nk;
        ack_ph = 1;
      end
    end
    p_scl = i2c_sclk;
    p_sda = sda;
  end
  int vectors = 0, miscompares = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  rec_t exp_q [$];
  bit m_done, m_err;
  int m_cnt;
  task automatic build_model();
    int k, nb;
    exp_q.delete();
    m_done = 1;
    m_err = 0;
    m_cnt = LUT - 1;
    for (int e = 0; e < LUT && !m_err; e++)
      for (int a = 0; a <= MR; a++) begin
        k = nack_tab[e][a];
        nb = k < 3 ? k + 1 : 3;
        exp_q.push_back({8'(e), 2'(nb), rom[e] & ~(24'hffffff >> (8 * nb))});
        if (k >= 3) break;
        if (a == MR) begin
          m_err = 1;
          m_done = 0;
          m_cnt = e;
        end
      end
  endtask
  task automatic check_log(int from);
    build_model();
    chk("attempt count", 64'(obs.size() - from), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && from + i < obs.size(); i++)
      chk($sformatf("attempt %0d {ent,nbytes,bytes}", i), 64'(obs[from+i]), 64'(exp_q[i]));
    chk("done", 64'(done), 64'(m_done));
    chk("error", 64'(error), 64'(m_err));
    chk("count", 64'(count), 64'(m_cnt));
    chk("scl idle", 64'(i2c_sclk), 64'(1));
    chk("sda idle", 64'(sda), 64'(1));
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    chk("sequence ends within budget", 64'(busy), 64'(0));
  endtask
  task automatic pulse_start();
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
  endtask
  task automatic set_policy(int ent, int byt, int times, bit rnd);
    for (int e = 0; e < 64; e++)
      for (int a = 0; a <= MR; a++)
        nack_tab[e][a] = rnd ? ($urandom_range(0, 5) == 0 ? int'($urandom_range(0, 2)) : 3) : (e == ent && a < times) ? byt : 3;
  endtask
  initial begin
    row_t rows [3];
    int n, from;
    rows[0] = '{3, 0, 2, 1'b1, 1'b0, 11};
    rows[1] = '{5, 1, 4, 1'b0, 1'b1, 5};
    rows[2] = '{0, 2, 4, 1'b0, 1'b1, 0};
    for (int e = 0; e < 64; e++) rom[e] = {8'h72, 8'($urandom), 8'($urandom)};
    rom[0] = 24'h724100;
    rom[LUT-1] = 24'h721800;
    set_policy(-1, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk("reset count", 64'(count), 64'(0));
    chk("reset scl", 64'(i2c_sclk), 64'(1));
    chk("reset sda", 64'(sda), 64'(1));
    chk("reset busy", 64'(busy), 64'(1));
    chk("reset done", 64'(done), 64'(0));
    chk("reset error", 64'(error), 64'(0));
    reset = 0;
    repeat (BOOT) @(negedge clock);
    chk("quiet bus during boot", 64'(obs.size() + int'(in_tx)), 64'(0));
    n = 0;
    while (!in_tx && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("first START soon after boot", 64'(in_tx), 64'(1));
    n = 0;
    while (!(in_tx && cur_ent == 2 && bitn == 3) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    pulse_start();
    chk("start ignored: busy", 64'(busy), 64'(1));
    chk("start ignored: count", 64'(count), 64'(2));
    wait_idle();
    check_log(0);
    if (obs.size() >= LUT) begin
      chk("first write", 64'(obs[0]), 64'({8'd0, 2'd3, 24'h724100}));
      chk("last write", 64'(obs[LUT-1]), 64'({8'd11, 2'd3, 24'h721800}));
    end
    for (int r = 0; r < 3; r++) begin
      set_policy(rows[r].ent, rows[r].byt, rows[r].times, 0);
      from = obs.size();
      pulse_start();
      chk($sformatf("row %0d restart busy", r), 64'(busy), 64'(1));
      chk($sformatf("row %0d restart done", r), 64'(done), 64'(0));
      chk($sformatf("row %0d restart error", r), 64'(error), 64'(0));
      chk($sformatf("row %0d restart count", r), 64'(count), 64'(0));
      wait_idle();
      check_log(from);
      chk($sformatf("row %0d done", r), 64'(done), 64'(rows[r].exp_done));
      chk($sformatf("row %0d error", r), 64'(error), 64'(rows[r].exp_err));
      chk($sformatf("row %0d count", r), 64'(count), 64'(rows[r].exp_cnt));
    end
    set_policy(-1, 0, 0, 0);
    pulse_start();
    n = 0;
    while (!(in_tx && cur_ent == 7 && nbytes == 0 && bitn == 4) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    chk("reach entry 7 bit 4", 64'(n < BUDGET), 64'(1));
    reset = 1;
    #1;
    chk("async reset scl", 64'(i2c_sclk), 64'(1));
    chk("async reset sda", 64'(sda), 64'(1));
    chk("async reset count", 64'(count), 64'(0));
    chk("async reset busy", 64'(busy), 64'(1));
    set_policy(-1, 0, 0, 1);
    repeat (2) @(negedge clock);
    from = obs.size();
    reset = 0;
    @(negedge clock);
    wait_idle();
    check_log(from);
`ifdef HPD_RECONFIG_EN
    set_policy(-1, 0, 0, 0);
    from = obs.size();
    @(negedge clock);
    hpd = 1;
    repeat (4) @(negedge clock);
    chk("hpd rerun busy", 64'(busy), 64'(1));
    chk("hpd rerun count", 64'(count), 64'(0));
    hpd = 0;
    repeat (5) @(negedge clock);
    hpd = 1;
    repeat (5) @(negedge clock);
    wait_idle();
    check_log(from);
    repeat (10) @(negedge clock);
    chk("hpd edge while busy dropped", 64'(busy), 64'(0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
